md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5: multiply latency in cycles, legal range 1..31.
REQ-003 SHALL have parameter DIV_LAT, default 10: divide latency in cycles, legal range 1..31.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request valid this cycle.
REQ-007 SHALL have port op, input, 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-008 SHALL have ports a and b, input, WIDTH: rs and rt operands.
REQ-009 SHALL have port busy, output, 1: an operation is in flight.
REQ-010 SHALL have port done, output, 1: one-cycle pulse on the cycle HI/LO take a mult/div result.
REQ-011 SHALL have ports hi and lo, output, WIDTH: registered HI and LO values.

Function
REQ-012 SHALL have states IDLE and RUN.
REQ-013 SHALL accept a request only when start=1, state=IDLE and op is 1..6; start while RUN is ignored.
REQ-014 mult/multu/div/divu accepted: SHALL latch the result, load counter with MULT_LAT or DIV_LAT, go to RUN, busy=1 from the next cycle.
REQ-015 In RUN, counter SHALL decrement each cycle; busy=1 for exactly LAT cycles after accept.
REQ-016 Counter reaching 1: SHALL write HI/LO at that edge, go to IDLE, busy=0 and done=1 for one cycle; a new start in that done cycle SHALL be accepted.
REQ-017 mult: SHALL form the signed 2*WIDTH product, hi=upper WIDTH bits, lo=lower; multu: unsigned.
REQ-018 div: lo=quotient truncated toward zero, hi=remainder carrying the dividend's sign; divu: unsigned.
REQ-019 Signed -2^(WIDTH-1) / -1: SHALL give lo=-2^(WIDTH-1), hi=0.
REQ-020 Divide by zero: SHALL run full DIV_LAT, pulse done, leave hi/lo unchanged.
REQ-021 mthi/mtlo: SHALL write a to hi/lo at the next edge; SHALL not assert busy or done; the other register SHALL stay unchanged.
REQ-022 hi/lo SHALL hold their value during RUN; intermediate state SHALL never be visible.
REQ-023 Pipeline stall request is busy OR (start AND op in 1..4); the hazard unit drives this, not this block.

Reset
REQ-024 reset low SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no HI/LO write; operation after release SHALL start from IDLE.

Configuration
REQ-026 With macro MD_UNIT_DIV_EN defined, div/divu SHALL behave per REQ-018..020.
REQ-027 Without MD_UNIT_DIV_EN, op 3/4 SHALL be no-ops (not accepted, no busy, no done, hi/lo unchanged) and no divider logic is synthesised.

Structure
REQ-028 Shared package md_pkg SHALL hold the op encodings, the IDLE/RUN state enum and the default latency constants.
REQ-029 The divider SHALL be one sub-module md_div_core (signed/unsigned quotient and remainder), instantiated only under MD_UNIT_DIV_EN.

Verification
REQ-030 reset low at cycle 3 of a mult, then released; a=5, b=7 mult issued -> hi=0, lo=0 after reset; result appears 5 cycles after the new issue.
REQ-031 mult a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after 5 cycles; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy high 10 cycles, done one cycle.
REQ-033 div a=0x80000000, b=-1 -> lo=0x80000000, hi=0; then div by 0 -> hi/lo unchanged, done pulses.
REQ-034 mthi a=0x1234 during RUN -> ignored; mtlo a=0xABCD in IDLE -> lo=0xABCD next cycle, busy=0.
REQ-035 Back-to-back: start multu in the done cycle of a previous mult -> accepted, no idle gap; rebuilt without MD_UNIT_DIV_EN, div start -> busy stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   // Wide enough for the largest legal latency (31).
   localparam int CNT_W        = 5;

endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned divider: truncating quotient, remainder takes
// the dividend's sign. Divide-by-zero is flagged and yields zero outputs.
module md_div_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b, mag_b_safe, mag_q, mag_r;

   // Divide magnitudes, then restore signs; -2^(W-1)/-1 falls out as 2^(W-1).
   always_comb begin
      neg_a      = is_signed & a[WIDTH-1];
      neg_b      = is_signed & b[WIDTH-1];
      mag_a      = neg_a ? (~a + 1'b1) : a;
      mag_b      = neg_b ? (~b + 1'b1) : b;
      div_zero   = (b == '0);
      mag_b_safe = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      mag_q      = mag_a / mag_b_safe;
      mag_r      = mag_a % mag_b_safe;
      q          = '0;
      r          = '0;
      if (!div_zero) begin
         q = (neg_a ^ neg_b) ? (~mag_q + 1'b1) : mag_q;
         r = neg_a ? (~mag_r + 1'b1) : mag_r;
      end
   end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit with fixed-latency IDLE/RUN sequencing.
// Divide support is built only when MD_UNIT_DIV_EN is defined.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output md_state_e        state_dbg
);

   // Handshake: a request (start with op 1..6) is taken on a rising edge only
   // while busy=0; there is no ready/ack beyond busy, so the requester must hold
   // off long ops until busy drops. done marks the cycle HI/LO show a result.

   md_state_e          state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               done_nxt, load_res, commit;
   logic               is_mul, is_div, is_long, signed_op, accept;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod, res_nxt;
   logic               skip_nxt;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               res_skip;

   assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign is_long   = is_mul || is_div;
   assign accept    = start && (state == IDLE) &&
                      (is_long || (op == OP_MTHI) || (op == OP_MTLO));

   assign ext_a = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign ext_b = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod  = ext_a * ext_b;

`ifdef MD_UNIT_DIV_EN
   logic [WIDTH-1:0] div_q, div_r;
   logic             div_zero;

   assign is_div = (op == OP_DIV) || (op == OP_DIVU);

   md_div_core #(.WIDTH(WIDTH)) u_div (
      .a         (a),
      .b         (b),
      .is_signed (signed_op),
      .q         (div_q),
      .r         (div_r),
      .div_zero  (div_zero)
   );

   always_comb begin
      res_nxt  = prod;
      skip_nxt = 1'b0;
      if (is_div) begin
         res_nxt  = {div_r, div_q};
         skip_nxt = div_zero;
      end
   end
`else
   assign is_div   = 1'b0;
   assign res_nxt  = prod;
   assign skip_nxt = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      load_res  = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && is_long) begin
               state_nxt = RUN;
               cnt_nxt   = is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
               load_res  = 1'b1;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               commit    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The result is computed at accept and parked in res_*; HI/LO only change
   // on the final edge so nothing intermediate is ever visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         res_hi   <= '0;
         res_lo   <= '0;
         res_skip <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
         if (load_res) begin
            res_hi   <= res_nxt[2*WIDTH-1:WIDTH];
            res_lo   <= res_nxt[WIDTH-1:0];
            res_skip <= skip_nxt;
         end
         if (commit) begin
            if (!res_skip) begin
               hi <= res_hi;
               lo <= res_lo;
            end
         end else if (accept && (op == OP_MTHI)) begin
            hi <= a;
         end else if (accept && (op == OP_MTLO)) begin
            lo <= a;
         end
      end
   end

   assign busy      = (state == RUN);
   assign state_dbg = state;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops checked
// against an arithmetic reference model. Honours MD_UNIT_DIV_EN.
module tb_md_unit;
   import md_pkg::*;

   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;
`ifdef MD_UNIT_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done;
   logic [W-1:0]  hi, lo;
   md_state_e     state_dbg;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [W-1:0]  mdl_hi = '0;
   logic [W-1:0]  mdl_lo = '0;
   logic [2*W-1:0] exp_q[$];

   md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .state_dbg (state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on wide integers.
   function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                                 input logic [W-1:0] y, input logic [W-1:0] h,
                                                 input logic [W-1:0] l);
      longint sx, sy, q, r;
      logic [63:0] pu;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ref_result = {h, l};
      case (o)
         3'd1: begin q = sx * sy; ref_result = q; end
         3'd2: begin pu = {32'b0, x} * {32'b0, y}; ref_result = pu; end
         3'd3, 3'd4: begin
            if (o == 3'd4) begin
               sx = longint'({32'b0, x});
               sy = longint'({32'b0, y});
            end
            if (y != 0) begin
               q = sx / sy;
               r = sx % sy;
               ref_result = {r[31:0], q[31:0]};
            end
         end
         default: ref_result = {h, l};
      endcase
   endfunction

   // Driver: issue one request, then follow it to completion and score it.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit poke);
      bit         is_long;
      int         lat, cyc;
      logic [2*W-1:0] e;
      is_long = (o == 3'd1) || (o == 3'd2) || (DIV_EN && ((o == 3'd3) || (o == 3'd4)));
      lat = (o <= 3'd2) ? ML : DL;
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0; op = 3'd0;
      chk("done_after_issue", done, 1'b0);
      if (is_long) begin
         exp_q.push_back(ref_result(o, x, y, mdl_hi, mdl_lo));
         cyc = 0;
         while (busy === 1'b1 && cyc < 40) begin
            chk("hold_hi", hi, mdl_hi);
            chk("hold_lo", lo, mdl_lo);
            chk("no_done_in_run", done, 1'b0);
            if (poke && cyc == 0) begin
               start = 1'b1; op = 3'd5; a = 32'h0000_1234;
            end
            cyc++;
            tick();
            start = 1'b0; op = 3'd0;
         end
         chk("busy_cycles", cyc, lat);
         chk("done_pulse", done, 1'b1);
         chk("idle_after", state_dbg, IDLE);
         e = exp_q.pop_front();
         mdl_hi = e[2*W-1:W];
         mdl_lo = e[W-1:0];
         chk("res_hi", hi, mdl_hi);
         chk("res_lo", lo, mdl_lo);
      end else begin
         if (o == 3'd5) mdl_hi = x;
         if (o == 3'd6) mdl_lo = x;
         chk("nolong_busy", busy, 1'b0);
         chk("nolong_done", done, 1'b0);
         chk("nolong_hi", hi, mdl_hi);
         chk("nolong_lo", lo, mdl_lo);
      end
   endtask

   initial begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;

      // reset block
      reset = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk("rst_state", state_dbg, IDLE);
      reset = 1'b1;
      tick();

      // preload so the mid-run reset has something to clear
      run_op(3'd6, 32'h0000_ABCD, '0, 1'b0);
      run_op(3'd5, 32'h5555_5555, '0, 1'b0);

      // reset in cycle 3 of a mult
      start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
      tick();
      start = 1'b0; op = 3'd0;
      tick(); tick();
      chk("pre_rst_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_hi", hi, '0);
      chk("async_rst_lo", lo, '0);
      mdl_hi = '0; mdl_lo = '0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < ML + 2; i++) begin
         tick();
         chk("aborted_busy", busy, 1'b0);
         chk("aborted_done", done, 1'b0);
         chk("aborted_lo", lo, '0);
      end

      // directed multiplies; consecutive run_op calls issue in the done cycle
      run_op(3'd1, 32'd5, 32'd7, 1'b0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
      chk("mult_neg_lo", lo, 32'hFFFF_FFFE);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      // mthi during RUN is dropped
      run_op(3'd1, 32'd3, 32'd3, 1'b1);
      chk("mthi_ignored", hi, 32'd0);
      run_op(3'd6, 32'h0000_ABCD, '0, 1'b0);
      chk("mtlo_lo", lo, 32'h0000_ABCD);

      // divides (no-ops unless divider built)
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      if (DIV_EN) begin
         chk("div_lo", lo, 32'hFFFF_FFFD);
         chk("div_hi", hi, 32'hFFFF_FFFF);
      end
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      if (DIV_EN) begin
         chk("div_ovf_lo", lo, 32'h8000_0000);
         chk("div_ovf_hi", hi, 32'h0000_0000);
      end
      run_op(3'd3, 32'd99, 32'd0, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd7, 32'd1, 32'd1, 1'b0);
      run_op(3'd0, 32'd1, 32'd1, 1'b0);

      // random ops
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
         case ($urandom_range(0, 5))
            0:       ry = '0;
            1:       ry = W'($urandom_range(1, 20));
            2:       ry = 32'hFFFF_FFFF;
            default: ry = W'($urandom);
         endcase
         run_op(ro, rx, ry, 1'b0);
         if ($urandom_range(0, 2) == 0) begin
            tick();
            chk("idle_gap_busy", busy, 1'b0);
            chk("idle_gap_done", done, 1'b0);
         end
      end

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
